tube_readout: RTL and testbench

- Downstream consumer of the per-tube cycle counters.
- Arms all tube channels and opens the gate window on a scintillator trigger.
- Snapshots every tube's 8-bit cycle count when the window closes, then streams a framed event packet byte-by-byte over a valid/ready interface to the host link.
- Owns the tube counters' clear and gate-enable lines; one instance serves the whole tube array.

---
 rtl/tube_pkg.sv | 20 ++
 rtl/tube_readout_tx.sv | 87 ++++++++
 rtl/tube_readout.sv | 160 ++++++++++++++++
 tb/tb_tube_readout.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// Shared definitions for the tube readout block.
//   state_t     : controller sequencing states
//   HEADER_BYTE : default first byte of every event packet
//   TUBE_CNT_W  : width of one tube cycle count
//   NO_HIT      : tube count meaning "no hit inside the gate window"
package tube_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    ARMED,
    GATE,
    SNAP,
    SEND
  } state_t;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;
  localparam int         TUBE_CNT_W  = 8;
  localparam logic [7:0] NO_HIT      = 8'hFF;

endpackage

// File: rtl/tube_readout_tx.sv
// Packet transmitter for the tube readout.
// On start it snapshots all tube counts and presents the header byte; it then
// walks header, event number and tube0..tube(N-1) over a valid/ready byte
// stream, one byte per accepted transfer.
// Ports:
//   clk, clr        : clock, asynchronous active-high reset
//   start           : one-cycle pulse, capture tube_data and begin a packet
//   tube_data       : packed tube counts, tube i at [8i+7:8i]
//   evt_num         : event number to place in the second byte
//   out_ready       : consumer accepts the current byte
//   out_data/valid  : registered byte stream
//   done            : combinational, high in the cycle the last byte transfers
module tube_readout_tx #(
  parameter int         NUM_TUBES   = 8,
  parameter logic [7:0] HEADER_BYTE = tube_pkg::HEADER_BYTE
) (
  input  logic                                     clk,
  input  logic                                     clr,
  input  logic                                     start,
  input  logic [tube_pkg::TUBE_CNT_W*NUM_TUBES-1:0] tube_data,
  input  logic [7:0]                               evt_num,
  input  logic                                     out_ready,
  output logic [7:0]                               out_data,
  output logic                                     out_valid,
  output logic                                     done
);

  localparam int SNAP_W = tube_pkg::TUBE_CNT_W * NUM_TUBES;
  localparam int IDX_W  = $clog2(NUM_TUBES + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TUBES + 1);

  // The snapshot is a shift register: the next tube to send is always in
  // the low byte, so no wide variable mux is needed.
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              xfer;

  assign xfer = valid_q & out_ready;
  assign done = xfer & (idx_q == LAST_IDX);

  always_comb begin
    snap_d  = snap_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (start) begin
      snap_d  = tube_data;
      idx_d   = '0;
      data_d  = HEADER_BYTE;
      valid_d = 1'b1;
    end else if (xfer) begin
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        data_d  = 8'h00;
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == '0) begin
          data_d = evt_num;
        end else begin
          data_d = snap_q[7:0];
          snap_d = snap_q >> 8;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      snap_q  <= '0;
      idx_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/tube_readout.sv
// Tube array readout controller.
// Clears and arms the tube counters, opens a gate window on a trigger,
// snapshots all tube counts when the window closes and streams a framed
// packet (header, event number, tube counts) to the host link.
// Ports:
//   clk, clr            : clock, asynchronous active-high reset
//   trigger             : scintillator trigger, synchronous level
//   tube_data           : packed tube counts, tube i at [8i+7:8i]
//   tube_clr, tube_gate : clear / gate-enable to all tube counters
//   out_data/valid/ready: byte stream to the host link
//   busy                : low only while ARMED
//   evt_num             : number of the next event to be sent
//   missed              : saturating count of triggers seen outside ARMED
module tube_readout #(
  parameter int         NUM_TUBES   = 8,
  parameter int         GATE_CYCLES = 200,
  parameter int         CLR_CYCLES  = 2,
  parameter logic [7:0] HEADER_BYTE = tube_pkg::HEADER_BYTE
) (
  input  logic                                     clk,
  input  logic                                     clr,
  input  logic                                     trigger,
  input  logic [tube_pkg::TUBE_CNT_W*NUM_TUBES-1:0] tube_data,
  output logic                                     tube_clr,
  output logic                                     tube_gate,
  output logic [7:0]                               out_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     busy,
  output logic [7:0]                               evt_num,
  output logic [7:0]                               missed
);

  import tube_pkg::*;

  localparam int CNT_W = 16;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tube_clr_q, tube_clr_d;
  logic             tube_gate_q, tube_gate_d;
  logic             busy_q, busy_d;
  logic [7:0]       evt_q, evt_d;
  logic [7:0]       missed_q, missed_d;
  logic             trig_prev_q, trig_prev_d;
  // Set when a trigger level has started an event; cleared once trigger
  // drops, so a held level cannot start a second event.
  logic             trig_used_q, trig_used_d;
  logic             tx_start, tx_done;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tube_clr_d  = tube_clr_q;
    tube_gate_d = tube_gate_q;
    busy_d      = busy_q;
    evt_d       = evt_q;
    missed_d    = missed_q;
    trig_prev_d = trigger;
    trig_used_d = trigger ? trig_used_q : 1'b0;
    tx_start    = 1'b0;

    if ((state_q != ARMED) && trigger && !trig_prev_q && (missed_q != 8'hFF)) begin
      missed_d = missed_q + 8'd1;
    end

    case (state_q)
      CLEAR: begin
        if (cnt_q == CNT_W'(CLR_CYCLES - 1)) begin
          state_d = ARMED;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARMED: begin
        if (trigger && !trig_used_q) begin
          state_d     = GATE;
          cnt_d       = '0;
          tube_clr_d  = 1'b0;
          tube_gate_d = 1'b1;
          busy_d      = 1'b1;
          trig_used_d = 1'b1;
        end
      end
      GATE: begin
        if (cnt_q == CNT_W'(GATE_CYCLES - 1)) begin
          state_d     = SNAP;
          cnt_d       = '0;
          tube_gate_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SNAP: begin
        tx_start = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        if (tx_done) begin
          state_d    = CLEAR;
          cnt_d      = '0;
          tube_clr_d = 1'b1;
          evt_d      = evt_q + 8'd1;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      tube_clr_q  <= 1'b1;
      tube_gate_q <= 1'b0;
      busy_q      <= 1'b1;
      evt_q       <= 8'h00;
      missed_q    <= 8'h00;
      trig_prev_q <= 1'b0;
      trig_used_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tube_clr_q  <= tube_clr_d;
      tube_gate_q <= tube_gate_d;
      busy_q      <= busy_d;
      evt_q       <= evt_d;
      missed_q    <= missed_d;
      trig_prev_q <= trig_prev_d;
      trig_used_q <= trig_used_d;
    end
  end

  tube_readout_tx #(
    .NUM_TUBES   (NUM_TUBES),
    .HEADER_BYTE (HEADER_BYTE)
  ) u_tx (
    .clk       (clk),
    .clr       (clr),
    .start     (tx_start),
    .tube_data (tube_data),
    .evt_num   (evt_q),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .done      (tx_done)
  );

  assign tube_clr  = tube_clr_q;
  assign tube_gate = tube_gate_q;
  assign busy      = busy_q;
  assign evt_num   = evt_q;
  assign missed    = missed_q;

endmodule

// File: tb/tb_tube_readout.sv
// Scoreboard bench for tube_readout: every triggered event pushes its
// expected packet into a queue; an independent monitor pops and compares
// each byte the DUT hands over.
module tb_tube_readout;
  import tube_pkg::*;

  localparam int NT = 8;
  localparam int GC = 200;
  localparam int CC = 2;

  logic            clk = 1'b0;
  logic            clr;
  logic            trigger;
  logic [8*NT-1:0] tube_data;
  logic            tube_clr, tube_gate, out_valid, out_ready, busy;
  logic [7:0]      out_data, evt_num, missed;

  tube_readout #(
    .NUM_TUBES   (NT),
    .GATE_CYCLES (GC),
    .CLR_CYCLES  (CC),
    .HEADER_BYTE (8'hA5)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .trigger   (trigger),
    .tube_data (tube_data),
    .tube_clr  (tube_clr),
    .tube_gate (tube_gate),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .evt_num   (evt_num),
    .missed    (missed)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         rx_cnt = 0;
  int         ready_mode = 1;   // 0 low, 1 high, 2 random
  logic [7:0] exp_q[$];
  logic [7:0] model_evt = 8'h00;
  int         model_missed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready driver: the only process that writes out_ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  // Monitor: compares every accepted byte and checks stall stability.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (clr) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_byte: got %0h expected no byte", out_data);
          end else begin
            e = exp_q.pop_front();
            check("pkt_byte", out_data, e);
          end
          rx_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_packet(input logic [8*NT-1:0] tubes);
    exp_q.push_back(8'hA5);
    exp_q.push_back(model_evt);
    for (int i = 0; i < NT; i++) exp_q.push_back(tubes[8*i +: 8]);
  endtask

  task automatic wait_armed();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    check("armed", busy, 0);
  endtask

  function automatic logic [8*NT-1:0] rand_tubes();
    logic [8*NT-1:0] t;
    for (int i = 0; i < NT; i++)
      t[8*i +: 8] = ($urandom_range(3) == 0) ? NO_HIT : 8'($urandom_range(255));
    return t;
  endfunction

  // One triggered event; n_miss extra trigger pulses are injected in GATE.
  task automatic run_event(input logic [8*NT-1:0] tubes, input int n_miss,
                           input bit bp, input bit b2b);
    int g, n, nv;
    wait_armed();
    tube_data = tubes;
    push_packet(tubes);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("gate_on", tube_gate, 1);
    check("clr_off", tube_clr, 0);
    g = 0;
    while (tube_gate === 1'b1 && g < 1000) begin
      trigger = (g > 0) && (g % 50 == 0) && (g / 50 <= n_miss);
      tick();
      g++;
    end
    trigger = 1'b0;
    check("gate_len", g, GC);
    model_missed = (model_missed + n_miss > 255) ? 255 : model_missed + n_miss;
    if (bp) begin
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      for (int k = 0; k < 5; k++) begin
        check("bp_valid", out_valid, 1);
        check("bp_header", out_data, 8'hA5);
        tick();
      end
      ready_mode = 1;
    end
    n  = 0;
    nv = 0;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && n < 2000) begin
      if (out_valid === 1'b1) nv++;
      tick();
      n++;
    end
    check("pkt_left", exp_q.size(), 0);
    if (b2b) check("b2b_cycles", nv, NT + 2);
    model_evt = model_evt + 8'd1;
    check("evt_num", evt_num, model_evt);
    check("missed", missed, model_missed);
  endtask

  initial begin
    logic [8*NT-1:0] t;
    int gcnt, n, base;
    clr       = 1'b1;
    trigger   = 1'b0;
    tube_data = '0;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;

    // Reset values and CLEAR duration.
    check("rst_clr", tube_clr, 1);
    check("rst_gate", tube_gate, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 1);
    check("rst_evt", evt_num, 0);
    check("rst_missed", missed, 0);
    tick();
    check("clear2_busy", busy, 1);
    check("clear2_clr", tube_clr, 1);
    tick();
    check("armed_busy", busy, 0);
    check("armed_clr", tube_clr, 1);
    check("armed_gate", tube_gate, 0);

    // Single event, back-to-back stream.
    t = {NT{NO_HIT}};
    t[7:0] = 8'd17;
    run_event(t, 0, 0, 1);

    // Backpressure on the header.
    ready_mode = 0;
    run_event(rand_tubes(), 0, 1, 0);

    // Triggers while busy are counted but start nothing.
    run_event(rand_tubes(), 3, 0, 1);
    repeat (300) tick();
    check("no_extra_busy", busy, 0);
    check("no_extra_q", exp_q.size(), 0);

    // Trigger held high for 1000 cycles -> exactly one event.
    wait_armed();
    t = rand_tubes();
    tube_data = t;
    push_packet(t);
    trigger = 1'b1;
    gcnt = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (tube_gate === 1'b1) gcnt++;
    end
    trigger = 1'b0;
    repeat (50) tick();
    check("held_gate_cycles", gcnt, GC);
    check("held_q", exp_q.size(), 0);
    model_evt = model_evt + 8'd1;
    check("held_evt", evt_num, model_evt);
    check("held_missed", missed, model_missed);

    // Reset after four bytes of a packet.
    wait_armed();
    ready_mode = 0;
    t = rand_tubes();
    tube_data = t;
    push_packet(t);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("abort_valid_seen", out_valid, 1);
    base = rx_cnt;
    ready_mode = 1;
    n = 0;
    while (rx_cnt < base + 4 && n < 100) begin
      tick();
      n++;
    end
    clr = 1'b1;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 1);
    check("abort_clr", tube_clr, 1);
    check("abort_evt", evt_num, 0);
    check("abort_left", exp_q.size(), NT + 2 - 4);
    exp_q.delete();
    model_evt    = 8'h00;
    model_missed = 0;
    tick();
    clr = 1'b0;

    // 256 random events with random backpressure: evt_num wraps.
    ready_mode = 2;
    for (int e = 0; e < 256; e++) run_event(rand_tubes(), $urandom_range(2), 0, 0);
    check("wrap_evt", evt_num, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
